// File: rtl/ex_mem_stall_if.sv
// EX->MEM stage bundle: pipeline control, EX-side instruction fields, and the
// registered MEM-side copies plus the multi-cycle accumulate loop-back.
interface ex_mem_stall_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
);
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush;
    logic                  ex_valid;
    logic [RADDR_W-1:0]    ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic                  ex_whilo;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [2*DATA_W-1:0]   hilo_temp_i;
    logic [CNT_W-1:0]      cnt_i;
    logic                  mem_valid;
    logic [RADDR_W-1:0]    mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_whilo;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [2*DATA_W-1:0]   hilo_temp_o;
    logic [CNT_W-1:0]      cnt_o;

    modport master (
        output stall_ex, stall_mem, flush, ex_valid, ex_wd, ex_wreg, ex_wdata,
               ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
               hilo_temp_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
    );

    modport slave (
        input  stall_ex, stall_mem, flush, ex_valid, ex_wd, ex_wreg, ex_wdata,
               ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
               hilo_temp_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_stall.sv
// EX->MEM pipeline register with flush/bubble/hold control and a loop-back
// path for multi-cycle accumulate state (hilo_temp / cnt) owned by EX.
module ex_mem_stall #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stall_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  mem_addr;
        logic [DATA_W-1:0]  reg2;
    } stage_t;

    stage_t              ex_stage_s;
    stage_t              stage_nxt_s;
    stage_t              stage_r;
    logic [2*DATA_W-1:0] temp_nxt_s;
    logic [2*DATA_W-1:0] temp_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [CNT_W-1:0]    cnt_r;

    // Collect the EX-side instruction fields into one stage record
    always_comb begin
        ex_stage_s.valid    = bus.ex_valid;
        ex_stage_s.wd       = bus.ex_wd;
        ex_stage_s.wreg     = bus.ex_wreg;
        ex_stage_s.wdata    = bus.ex_wdata;
        ex_stage_s.whilo    = bus.ex_whilo;
        ex_stage_s.hi       = bus.ex_hi;
        ex_stage_s.lo       = bus.ex_lo;
        ex_stage_s.aluop    = bus.ex_aluop;
        ex_stage_s.mem_addr = bus.ex_mem_addr;
        ex_stage_s.reg2     = bus.ex_reg2;
    end

    // Priority decode: flush, then the stall pair selects bubble/hold/advance
    always_comb begin
        stage_nxt_s = stage_r;
        temp_nxt_s  = '0;
        cnt_nxt_s   = '0;
        if (bus.flush) begin
            stage_nxt_s = '0;
        end else begin
            case ({bus.stall_ex, bus.stall_mem})
                2'b10: begin
                    stage_nxt_s = '0;
                    temp_nxt_s  = bus.hilo_temp_i;
                    cnt_nxt_s   = bus.cnt_i;
                end
                2'b11: begin
                    stage_nxt_s = stage_r;
                    temp_nxt_s  = bus.hilo_temp_i;
                    cnt_nxt_s   = bus.cnt_i;
                end
                2'b00: begin
                    stage_nxt_s = ex_stage_s;
                end
                // MEM stalled under a running EX: freeze the entry, drop the loop state
                2'b01: begin
                    stage_nxt_s = stage_r;
                end
                default: begin
                    stage_nxt_s = '0;
                end
            endcase
        end
    end

    // Stage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_r <= '0;
            temp_r  <= '0;
            cnt_r   <= '0;
        end else begin
            stage_r <= stage_nxt_s;
            temp_r  <= temp_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign bus.mem_valid    = stage_r.valid;
    assign bus.mem_wd       = stage_r.wd;
    assign bus.mem_wreg     = stage_r.wreg;
    assign bus.mem_wdata    = stage_r.wdata;
    assign bus.mem_whilo    = stage_r.whilo;
    assign bus.mem_hi       = stage_r.hi;
    assign bus.mem_lo       = stage_r.lo;
    assign bus.mem_aluop    = stage_r.aluop;
    assign bus.mem_mem_addr = stage_r.mem_addr;
    assign bus.mem_reg2     = stage_r.reg2;
    assign bus.hilo_temp_o  = temp_r;
    assign bus.cnt_o        = cnt_r;

    ex_mem_stall_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .stall_ex  (bus.stall_ex),
        .stall_mem (bus.stall_mem),
        .flush     (bus.flush)
    );
endmodule

// Flags the controller driving stall_mem without stall_ex on an unflushed edge.
module ex_mem_stall_chk (
    input logic clk,
    input logic rst,
    input logic stall_ex,
    input logic stall_mem,
    input logic flush
);
    // Illegal stall combination check, ignored under reset or flush
    always @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(!stall_ex && stall_mem))
                else $error("ex_mem_stall: stall_mem asserted without stall_ex");
        end
    end
endmodule

// File: tb/tb_ex_mem_stall.sv
// Bench for ex_mem_stall: directed literal checks followed by random traffic,
// with every cycle compared against a rule-level model of the stage.
module tb_ex_mem_stall;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_stall_if #(.DATA_W(DW), .RADDR_W(RW), .ALUOP_W(AW), .CNT_W(CW)) bus ();

    ex_mem_stall #(.DATA_W(DW), .RADDR_W(RW), .ALUOP_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic          whilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [AW-1:0] aluop;
        logic [DW-1:0] addr;
        logic [DW-1:0] reg2;
        logic [2*DW-1:0] temp;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t exp_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic obs_t sample_ex();
        obs_t o;
        o = '0;
        o.valid = bus.ex_valid;  o.wd = bus.ex_wd;       o.wreg = bus.ex_wreg;
        o.wdata = bus.ex_wdata;  o.whilo = bus.ex_whilo; o.hi = bus.ex_hi;
        o.lo = bus.ex_lo;        o.aluop = bus.ex_aluop; o.addr = bus.ex_mem_addr;
        o.reg2 = bus.ex_reg2;
        return o;
    endfunction

    function automatic obs_t sample_out();
        obs_t o;
        o.valid = bus.mem_valid;  o.wd = bus.mem_wd;       o.wreg = bus.mem_wreg;
        o.wdata = bus.mem_wdata;  o.whilo = bus.mem_whilo; o.hi = bus.mem_hi;
        o.lo = bus.mem_lo;        o.aluop = bus.mem_aluop; o.addr = bus.mem_mem_addr;
        o.reg2 = bus.mem_reg2;    o.temp = bus.hilo_temp_o; o.cnt = bus.cnt_o;
        return o;
    endfunction

    // What the stage must hold after this edge, from the priority rules
    function automatic obs_t model_next(input obs_t cur);
        obs_t n;
        n = cur;
        if (!rst || bus.flush) begin
            n = '0;
        end else if (bus.stall_ex) begin
            if (!bus.stall_mem) n = '0;
            n.temp = bus.hilo_temp_i;
            n.cnt  = bus.cnt_i;
        end else begin
            if (!bus.stall_mem) n = sample_ex();
            n.temp = '0;
            n.cnt  = '0;
        end
        return n;
    endfunction

    always @(posedge clk) exp_m <= model_next(exp_m);

    task automatic compare_all(input obs_t a, input obs_t e);
        chk("valid", 64'(a.valid), 64'(e.valid));
        chk("wd",    64'(a.wd),    64'(e.wd));
        chk("wreg",  64'(a.wreg),  64'(e.wreg));
        chk("wdata", 64'(a.wdata), 64'(e.wdata));
        chk("whilo", 64'(a.whilo), 64'(e.whilo));
        chk("hi",    64'(a.hi),    64'(e.hi));
        chk("lo",    64'(a.lo),    64'(e.lo));
        chk("aluop", 64'(a.aluop), 64'(e.aluop));
        chk("addr",  64'(a.addr),  64'(e.addr));
        chk("reg2",  64'(a.reg2),  64'(e.reg2));
        chk("temp",  a.temp,       e.temp);
        chk("cnt",   64'(a.cnt),   64'(e.cnt));
    endtask

    always @(negedge clk) begin
        if (check_en) compare_all(sample_out(), exp_m);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ex_ones();
        bus.ex_valid = 1'b1;  bus.ex_wd = '1;       bus.ex_wreg = 1'b1;
        bus.ex_wdata = '1;    bus.ex_whilo = 1'b1;  bus.ex_hi = '1;
        bus.ex_lo = '1;       bus.ex_aluop = '1;    bus.ex_mem_addr = '1;
        bus.ex_reg2 = '1;     bus.hilo_temp_i = '1; bus.cnt_i = '1;
    endtask

    initial begin
        rst = 1'b0;
        bus.stall_ex = 1'b0; bus.stall_mem = 1'b0; bus.flush = 1'b0;
        set_ex_ones();
        tick();
        tick();
        check_en = 1'b1;
        chk("reset_all_zero", 64'(sample_out() != '0), 64'd0);
        chk("reset_valid", 64'(bus.mem_valid), 64'd0);

        rst = 1'b1;
        tick();
        chk("release_wdata", 64'(bus.mem_wdata), 64'h0000_0000_FFFF_FFFF);
        chk("release_temp", bus.hilo_temp_o, 64'd0);

        bus.ex_wd = 5'd5; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'hDEAD_BEEF; bus.ex_valid = 1'b1;
        tick();
        chk("adv_wd", 64'(bus.mem_wd), 64'd5);
        chk("adv_wreg", 64'(bus.mem_wreg), 64'd1);
        chk("adv_wdata", 64'(bus.mem_wdata), 64'h0000_0000_DEAD_BEEF);
        chk("adv_valid", 64'(bus.mem_valid), 64'd1);
        chk("adv_temp", bus.hilo_temp_o, 64'd0);

        bus.stall_ex = 1'b1; bus.stall_mem = 1'b0;
        bus.hilo_temp_i = 64'h1_0000_0002; bus.cnt_i = 2'd1;
        tick();
        chk("bub_wreg", 64'(bus.mem_wreg), 64'd0);
        chk("bub_valid", 64'(bus.mem_valid), 64'd0);
        chk("bub_temp", bus.hilo_temp_o, 64'h1_0000_0002);
        chk("bub_cnt", 64'(bus.cnt_o), 64'd1);

        bus.stall_ex = 1'b0; bus.ex_wdata = 32'h1234;
        tick();
        chk("hold_load", 64'(bus.mem_wdata), 64'h1234);
        chk("hold_load_cnt", 64'(bus.cnt_o), 64'd0);
        bus.stall_ex = 1'b1; bus.stall_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_wdata = 32'hA5A5_0000 + 32'(i);
            tick();
            chk("hold_wdata", 64'(bus.mem_wdata), 64'h1234);
        end

        bus.flush = 1'b1;
        tick();
        chk("flush_all_zero", 64'(sample_out() != '0), 64'd0);

        bus.flush = 1'b0; bus.stall_ex = 1'b1; bus.stall_mem = 1'b0;
        bus.cnt_i = 2'd1; bus.hilo_temp_i = 64'h0000_00AB_0000_00CD;
        tick();
        chk("madd_cnt", 64'(bus.cnt_o), 64'd1);
        chk("madd_temp", bus.hilo_temp_o, 64'h0000_00AB_0000_00CD);
        rst = 1'b0;
        tick();
        chk("midop_rst_cnt", 64'(bus.cnt_o), 64'd0);
        chk("midop_rst_temp", bus.hilo_temp_o, 64'd0);
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(31) != 0);
            bus.flush = ($urandom_range(15) == 0);
            bus.stall_ex = 1'($urandom_range(1));
            bus.stall_mem = bus.stall_ex ? 1'($urandom_range(1)) : 1'b0;
            bus.ex_valid = 1'($urandom_range(1));
            bus.ex_wd = RW'($urandom());
            bus.ex_wreg = 1'($urandom_range(1));
            bus.ex_wdata = $urandom();
            bus.ex_whilo = 1'($urandom_range(1));
            bus.ex_hi = $urandom();
            bus.ex_lo = $urandom();
            bus.ex_aluop = AW'($urandom());
            bus.ex_mem_addr = $urandom();
            bus.ex_reg2 = $urandom();
            bus.hilo_temp_i = {$urandom(), $urandom()};
            bus.cnt_i = CW'($urandom());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
